// File: rtl/adder_vec_pkg.sv
// Shared types and constants for the adder test-vector generator.
package adder_vec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step: feedback taps are XORed in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
module lfsr16
  import adder_vec_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/adder_vec_gen.sv
// Adder stimulus generator: exhaustive {a,b,cin} sweep, or LFSR-driven vectors
// when ADDER_VEC_GEN_LFSR_EN is defined. Valid/ready handshake on the output.
module adder_vec_gen
  import adder_vec_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int          NUM_VECS = 256,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_cin,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic                 done,
  output logic [2*WIDTH+1:0]   vec_count
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = 2 * WIDTH + 2;

  state_e          state_q, state_d;
  logic [CW-1:0]   vec_count_q, vec_count_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic            xfer;
  logic            last;
  logic [CW-1:0]   cnt_inc;
  logic [VW-1:0]   start_vec;
  logic [VW-1:0]   next_vec;

`ifdef ADDER_VEC_GEN_LFSR_EN
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECS - 1);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nxt;
  logic        lfsr_load;
  logic        unused_lfsr;

  assign lfsr_load   = start && (state_q != RUN);
  assign lfsr_nxt    = lfsr_next(lfsr_q);
  assign start_vec   = SEED[VW-1:0];
  assign next_vec    = lfsr_nxt[VW-1:0];
  assign unused_lfsr = ^lfsr_nxt[15:VW];

  lfsr16 #(.RESET_VAL(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED),
    .step (xfer),
    .q    (lfsr_q)
  );
`else
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << VW) - 1);

  logic unused_cfg;

  assign start_vec  = '0;
  assign next_vec   = cnt_inc[VW-1:0];
  assign unused_cfg = ^{SEED, 32'(NUM_VECS)};
`endif

  // vec_count doubles as the vector index: both clear on start and advance per transfer.
  assign xfer    = valid_q && in_ready;
  assign last    = (vec_count_q == LAST_IDX);
  assign cnt_inc = vec_count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (xfer && last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_count_d = vec_count_q;
    vec_d       = vec_q;
    valid_d     = valid_q;
    done_d      = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_count_d = '0;
          vec_d       = start_vec;
          valid_d     = 1'b1;
          done_d      = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          vec_count_d = cnt_inc;
          if (last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = next_vec;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count_q <= '0;
      vec_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      vec_count_q <= vec_count_d;
      vec_q       <= vec_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign done      = done_q;
  assign vec_count = vec_count_q;
  assign out_a     = vec_q[VW-1:WIDTH+1];
  assign out_b     = vec_q[WIDTH:1];
  assign out_cin   = vec_q[0];

  always_comb begin
    {out_cout, out_sum} = (WIDTH+1)'(out_a) + (WIDTH+1)'(out_b) + (WIDTH+1)'(out_cin);
  end

endmodule

// File: tb/tb_adder_vec_gen.sv
// Self-checking bench for adder_vec_gen; exercises LFSR mode when ADDER_VEC_GEN_LFSR_EN is defined.
module tb_adder_vec_gen;

  localparam logic [15:0] SEED = 16'hACE1;
`ifdef ADDER_VEC_GEN_LFSR_EN
  localparam int TOTAL4 = 10;
`else
  localparam int TOTAL4 = 512;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, rdy1 = 1'b0;
  logic start4 = 1'b0, rdy4 = 1'b0;

  logic       v1, a1, b1, c1, s1, co1, d1;
  logic [3:0] cnt1;
  logic       v4, c4, co4, d4;
  logic [3:0] a4, b4, s4;
  logic [9:0] cnt4;

  always #5 clk = ~clk;

  adder_vec_gen #(.WIDTH(1), .NUM_VECS(8), .SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_ready(rdy1),
    .out_valid(v1), .out_a(a1), .out_b(b1), .out_cin(c1),
    .out_sum(s1), .out_cout(co1), .done(d1), .vec_count(cnt1)
  );

  adder_vec_gen #(.WIDTH(4), .NUM_VECS(10), .SEED(SEED)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_ready(rdy4),
    .out_valid(v4), .out_a(a4), .out_b(b4), .out_cin(c4),
    .out_sum(s4), .out_cout(co4), .done(d4), .vec_count(cnt4)
  );

  // Reference: the idx-th generated {a,b,cin} for the WIDTH=4 instance.
  function automatic logic [8:0] model_vec4(input int unsigned idx);
`ifdef ADDER_VEC_GEN_LFSR_EN
    logic [15:0] s;
    s = SEED;
    for (int unsigned i = 0; i < idx; i++) begin
      if ((s & 16'h0001) != 16'h0000) s = (s >> 1) ^ 16'hB400;
      else s = s >> 1;
    end
    return s[8:0];
`else
    return 9'(idx % 512);
`endif
  endfunction

  // Packed as {a, b, cin, cout, sum}, derived by plain arithmetic.
  function automatic logic [13:0] model_out4(input int unsigned idx);
    int v, a, b, c, t;
    v = int'(model_vec4(idx));
    a = v / 32;
    b = (v / 2) % 16;
    c = v % 2;
    t = a + b + c;
    return {4'(a), 4'(b), 1'(c), 1'(t / 16), 4'(t % 16)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; rdy1 = 1'b0; rdy4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({v4, d4, cnt4, a4, b4, c4} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_w4: got valid=%b done=%b cnt=%0d a=%0d b=%0d cin=%b, expected all 0", v4, d4, cnt4, a4, b4, c4);
    end
    n_tests++;
    if ({v1, d1, cnt1, a1, b1, c1, s1, co1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_w1: got %b, expected all 0", {v1, d1, cnt1, a1, b1, c1, s1, co1});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({v4, d4} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_start: got valid=%b done=%b, expected 0 0", v4, d4);
    end
  endtask

`ifndef ADDER_VEC_GEN_LFSR_EN
  task automatic test_width1();
    logic [1:0] tbl [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    int k = 0;
    int cyc = 0;
    rdy1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (!d1 && cyc < 40) begin
      if (v1) begin
        n_tests++;
        if (k >= 8) begin
          n_fail++;
          $display("FAIL w1_extra_vec: got vector %0d, expected only 8", k);
        end else if ({a1, b1, c1} !== 3'(k) || {co1, s1} !== tbl[k]) begin
          n_fail++;
          $display("FAIL w1_vec%0d: got abc=%b cout_sum=%b, expected abc=%b cout_sum=%b",
                   k, {a1, b1, c1}, {co1, s1}, 3'(k), tbl[k]);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    rdy1 = 1'b0;
    n_tests++;
    if (d1 !== 1'b1 || v1 !== 1'b0 || cnt1 !== 4'd8 || k != 8) begin
      n_fail++;
      $display("FAIL w1_done: got done=%b valid=%b cnt=%0d seen=%0d, expected 1 0 8 8", d1, v1, cnt1, k);
    end
  endtask

  task automatic test_stall();
    int seen [512];
    int k = 0;
    int cyc = 0;
    int errs = 0;
    logic stalled = 1'b0;
    logic [13:0] held = '0;
    foreach (seen[i]) seen[i] = 0;
    do_reset();
    pulse_start4();
    while (!d4 && cyc < 4000) begin
      if (stalled) begin
        n_tests++;
        if ({a4, b4, c4, co4, s4} !== held || v4 !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got %h valid=%b, expected %h valid=1", {a4, b4, c4, co4, s4}, v4, held);
        end
      end
      rdy4 = (cyc % 4 == 0) || (cyc % 4 == 3);
      stalled = 1'b0;
      if (v4) begin
        if (rdy4) begin
          n_tests++;
          if ({a4, b4, c4, co4, s4} !== model_out4(k)) begin
            n_fail++;
            $display("FAIL stall_vec%0d: got %h, expected %h", k, {a4, b4, c4, co4, s4}, model_out4(k));
          end
          if (k == 511) begin
            n_tests++;
            if ({a4, b4, c4, s4, co4} !== {4'd15, 4'd15, 1'b1, 4'd15, 1'b1}) begin
              n_fail++;
              $display("FAIL vec511: got a=%0d b=%0d cin=%b sum=%0d cout=%b, expected 15 15 1 15 1", a4, b4, c4, s4, co4);
            end
          end
          seen[{a4, b4, c4}]++;
          k++;
        end else begin
          stalled = 1'b1;
          held = {a4, b4, c4, co4, s4};
        end
      end
      @(negedge clk);
      cyc++;
    end
    rdy4 = 1'b0;
    foreach (seen[i]) if (seen[i] != 1) errs++;
    n_tests++;
    if (errs != 0 || k != 512) begin
      n_fail++;
      $display("FAIL coverage: got %0d transfers, %0d vectors not seen exactly once, expected 512 and 0", k, errs);
    end
    n_tests++;
    if (d4 !== 1'b1 || v4 !== 1'b0 || cnt4 !== 10'd512) begin
      n_fail++;
      $display("FAIL w4_done: got done=%b valid=%b cnt=%0d, expected 1 0 512", d4, v4, cnt4);
    end
  endtask
`endif

  task automatic test_reset_midrun();
    int target = (TOTAL4 > 100) ? 100 : 5;
    int k = 0;
    int cyc = 0;
    do_reset();
    pulse_start4();
    while (cnt4 != 10'(target) && cyc < 2000) begin
      rdy4 = 1'($urandom_range(0, 1));
      if (v4 && rdy4) begin
        n_tests++;
        if ({a4, b4, c4, co4, s4} !== model_out4(k)) begin
          n_fail++;
          $display("FAIL rand_vec%0d: got %h, expected %h", k, {a4, b4, c4, co4, s4}, model_out4(k));
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cnt4 != 10'(target)) begin
      n_fail++;
      $display("FAIL reach_count: got cnt=%0d, expected %0d within budget", cnt4, target);
    end
    rst = 1'b1;
    rdy4 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (v4 !== 1'b0 || cnt4 !== 10'd0 || d4 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst: got valid=%b cnt=%0d done=%b, expected 0 0 0", v4, cnt4, d4);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (v4 !== 1'b0 || cnt4 !== 10'd0) begin
      n_fail++;
      $display("FAIL no_auto_restart: got valid=%b cnt=%0d, expected 0 0", v4, cnt4);
    end
    pulse_start4();
    n_tests++;
    if (v4 !== 1'b1 || cnt4 !== 10'd0 || {a4, b4, c4, co4, s4} !== model_out4(0)) begin
      n_fail++;
      $display("FAIL restart_first: got valid=%b cnt=%0d vec=%h, expected 1 0 %h", v4, cnt4, {a4, b4, c4, co4, s4}, model_out4(0));
    end
    rdy4 = 1'b0;
  endtask

  task automatic test_start_in_run();
    int cyc = 0;
    do_reset();
    rdy4 = 1'b1;
    pulse_start4();
    while (cnt4 != 10'd5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n_tests++;
    if (cnt4 !== 10'd6 || v4 !== 1'b1 || {a4, b4, c4, co4, s4} !== model_out4(6)) begin
      n_fail++;
      $display("FAIL start_in_run: got cnt=%0d valid=%b vec=%h, expected 6 1 %h", cnt4, v4, {a4, b4, c4, co4, s4}, model_out4(6));
    end
    cyc = 0;
    while (cnt4 != 10'(TOTAL4 - 1) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n_tests++;
    if (d4 !== 1'b1 || v4 !== 1'b0 || cnt4 !== 10'(TOTAL4)) begin
      n_fail++;
      $display("FAIL start_at_last: got done=%b valid=%b cnt=%0d, expected 1 0 %0d", d4, v4, cnt4, TOTAL4);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (d4 !== 1'b1 || v4 !== 1'b0 || cnt4 !== 10'(TOTAL4)) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b valid=%b cnt=%0d, expected 1 0 %0d", d4, v4, cnt4, TOTAL4);
    end
    rdy4 = 1'b0;
  endtask

`ifdef ADDER_VEC_GEN_LFSR_EN
  task automatic test_lfsr_back_to_back();
    logic [8:0] runs [2][10];
    logic [15:0] sd;
    int k;
    int cyc;
    sd = SEED;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pulse_start4();
      k = 0;
      cyc = 0;
      while (!d4 && cyc < 200) begin
        rdy4 = 1'($urandom_range(0, 1));
        if (v4 && rdy4) begin
          if (k < 10) runs[r][k] = {a4, b4, c4};
          n_tests++;
          if (5'({co4, s4}) !== 5'(32'(a4) + 32'(b4) + 32'(c4))) begin
            n_fail++;
            $display("FAIL lfsr_sum r%0d v%0d: got cout_sum=%b for a=%0d b=%0d cin=%b", r, k, {co4, s4}, a4, b4, c4);
          end
          k++;
        end
        @(negedge clk);
        cyc++;
      end
      rdy4 = 1'b0;
      n_tests++;
      if (k != 10 || cnt4 !== 10'd10 || d4 !== 1'b1) begin
        n_fail++;
        $display("FAIL lfsr_run%0d_len: got %0d transfers cnt=%0d done=%b, expected 10 10 1", r, k, cnt4, d4);
      end
    end
    n_tests++;
    if (runs[0][0] !== sd[8:0]) begin
      n_fail++;
      $display("FAIL lfsr_first: got %h, expected %h", runs[0][0], sd[8:0]);
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (runs[0][i] !== model_vec4(i) || runs[1][i] !== runs[0][i]) begin
        n_fail++;
        $display("FAIL lfsr_seq%0d: got run0=%h run1=%h, expected %h", i, runs[0][i], runs[1][i], model_vec4(i));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef ADDER_VEC_GEN_LFSR_EN
    test_width1();
    test_stall();
`endif
    test_reset_midrun();
    test_start_in_run();
`ifdef ADDER_VEC_GEN_LFSR_EN
    test_lfsr_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_vec_gen.md
ADDER_VEC_GEN -- requirements
Module: adder_vec_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width; legal range 1..7.
REQ-002 The block SHALL have parameter NUM_VECS, default 256, giving the vector count in LFSR mode; ignored otherwise.
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, giving the nonzero LFSR seed.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle pulse; begins a vector run.
REQ-007 in_ready  input  1  consumer accepts the current vector.
REQ-008 out_valid  output  1  current vector is valid.
REQ-009 out_a, out_b  output  WIDTH each  operands.
REQ-010 out_cin  output  1  carry-in.
REQ-011 out_sum  output  WIDTH  expected sum, i.e. (out_a+out_b+out_cin) mod 2^WIDTH.
REQ-012 out_cout  output  1  expected carry-out.
REQ-013 done  output  1  run complete.
REQ-014 vec_count  output  2*WIDTH+2  number of vectors accepted in the current or last run.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL enter RUN on the next edge, load index 0, clear vec_count, deassert done and assert out_valid.
REQ-017 In RUN, start SHALL be ignored.
REQ-018 A vector SHALL transfer only in a cycle where out_valid=1 and in_ready=1; on transfer, index and vec_count SHALL increment on that edge.
REQ-019 While out_valid=1 and in_ready=0, all out_* SHALL hold stable.
REQ-020 In exhaustive mode, the vector for index i SHALL be out_a=i[2W:W+1], out_b=i[W:1] and out_cin=i[0], where W=WIDTH; a run is 2^(2W+1) vectors.
REQ-021 {out_cout,out_sum} SHALL be the combinational function of the registered out_a, out_b and out_cin, so there is zero added latency.
REQ-022 On transfer of the last vector, the FSM SHALL go to DONE, drive out_valid=0 and done=1, and hold vec_count at the total.
REQ-023 Index arithmetic SHALL be at least 2W+2 bits wide, so that the last-vector test has no wrap-around alias.
REQ-024 DONE SHALL hold until start or rst.
REQ-025 A start in the same cycle as the final transfer SHALL be ignored; that cycle ends in DONE.

Reset
REQ-026 While rst=1, the state SHALL be IDLE, out_valid=0, done=0, vec_count=0, out_a=0, out_b=0, out_cin=0, and the LFSR SHALL equal SEED.
REQ-027 rst asserted mid-run SHALL abort the run immediately, with no further transfers; after rst, a new start is required.

Configuration
REQ-028 When ADDER_VEC_GEN_LFSR_EN is defined, vectors SHALL come from a 16-bit Galois LFSR (polynomial 16'hB400) instead of the index: {out_a,out_b,out_cin}=lfsr[2W:0].
REQ-029 In LFSR mode, the LFSR SHALL advance once per transfer, the run SHALL be NUM_VECS vectors, and start SHALL reload SEED, so every run repeats the same sequence.
REQ-030 When ADDER_VEC_GEN_LFSR_EN is not defined, there SHALL be no LFSR logic and the mode SHALL be exhaustive only.

Structure
REQ-031 Package adder_vec_pkg SHALL hold the state enum (IDLE/RUN/DONE), the LFSR polynomial constant and the default seed.
REQ-032 The LFSR SHALL be a sub-module lfsr16 (ports clk, rst, load, seed, step, q), instantiated only under ADDER_VEC_GEN_LFSR_EN.

Verification
REQ-033 Check: WIDTH=1, exhaustive, in_ready tied 1, start pulse -> 8 vectors in order 000..111; expected {cout,sum} 00,01,01,10,01,10,10,11; then done=1, vec_count=8.
REQ-034 Check: WIDTH=4, in_ready toggling 1-0-0-1 -> out_* stable during each stall; all 512 vectors seen exactly once; the vector at index 511 is a=15, b=15, cin=1, sum=15, cout=1.
REQ-035 Check: rst asserted at vec_count=100 -> next edge gives out_valid=0 and vec_count=0; start after rst -> the first vector is a=0, b=0, cin=0.
REQ-036 Check: start during RUN at vec_count=5 -> no restart, and the count continues to 6; start coinciding with the final transfer -> state DONE.
REQ-037 Check: ADDER_VEC_GEN_LFSR_EN, NUM_VECS=10, two back-to-back runs -> identical 10-vector sequences; the first vector equals SEED[2W:0]; every sum and cout matches a+b+cin.
